// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - trap codes, FSM states and helpers for the trap controller
package trap_ctrl_pkg;

    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    localparam logic [31:0] EXC_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] EXC_ECALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_MRET    = 32'h0000_000a;

    localparam logic [3:0]  INT_CODE_SOFT  = 4'd0;
    localparam logic [3:0]  INT_CODE_TIMER = 4'd7;
    localparam logic [3:0]  INT_CODE_EXT   = 4'd11;

    localparam int MSTATUS_MIE = 3;
    localparam int MIE_MEIE    = 11;
    localparam int MIE_MTIE    = 7;
    localparam int MIE_MSIE    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAP   = 2'd1,
        ST_SETTLE = 2'd2
    } trap_state_e;

    function automatic logic [31:0] int_cause(input logic [3:0] code);
        return {1'b1, 27'b0, code};
    endfunction

    // Only these synchronous causes are honoured; anything else reads as "no exception".
    function automatic logic is_sync_exc(input logic [31:0] excepttype);
        return (excepttype == EXC_ECALL) || (excepttype == EXC_ILLEGAL) ||
               (excepttype == EXC_MRET);
    endfunction

endpackage

// File: rtl/trap_ctrl_sync_ff.sv
// rtl/trap_ctrl_sync_ff.sv - multi-flop single-bit synchronizer with async reset
module trap_ctrl_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/interrupt controller: priority select, redirect PC, TRAP/SETTLE sequencing
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_int_i,
    input  logic        timer_int_i,
    input  logic        soft_int_i,
    input  logic [31:0] mem_excepttype_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [2:0]  int_pending_o
);

    trap_state_e r_state;
    trap_state_e w_state_next;

    logic        w_ext_sync;
    logic        r_timer_pend;
    logic        r_soft_pend;

    logic        w_eligible;
    logic        w_int_en;
    logic        w_take;
    logic        w_is_int;
    logic [3:0]  w_int_code;
    logic [31:0] w_code;
    logic [31:0] w_base;
    logic [31:0] w_new_pc;

    logic [31:0] r_excepttype;
    logic [31:0] r_inst_addr;
    logic        r_flush;
    logic [31:0] r_new_pc;

    logic        w_unused;

    trap_ctrl_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ext_int_i),
        .q_o (w_ext_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_timer_pend <= 1'b0;
            r_soft_pend  <= 1'b0;
        end else begin
            r_timer_pend <= timer_int_i;
            r_soft_pend  <= soft_int_i;
        end
    end

    assign int_pending_o = {w_ext_sync, r_timer_pend, r_soft_pend};
    assign w_eligible    = (r_state == ST_IDLE) && mem_inst_valid_i && !stall_i;
    assign w_int_en      = mstatus_i[MSTATUS_MIE];
    assign w_base        = {mtvec_i[31:2], 2'b00};

    // Exceptions win over interrupts: the CSR file saves PC+4 on interrupts, which would skip ecall/mret.
    always_comb begin
        w_take     = 1'b0;
        w_is_int   = 1'b0;
        w_int_code = INT_CODE_SOFT;
        w_code     = ZERO_WORD;
        if (w_eligible) begin
            if (is_sync_exc(mem_excepttype_i)) begin
                w_take = 1'b1;
                w_code = mem_excepttype_i;
            end else if (w_int_en && w_ext_sync && mie_i[MIE_MEIE]) begin
                w_take     = 1'b1;
                w_is_int   = 1'b1;
                w_int_code = INT_CODE_EXT;
                w_code     = int_cause(INT_CODE_EXT);
            end else if (w_int_en && r_soft_pend && mie_i[MIE_MSIE]) begin
                w_take     = 1'b1;
                w_is_int   = 1'b1;
                w_int_code = INT_CODE_SOFT;
                w_code     = int_cause(INT_CODE_SOFT);
            end else if (w_int_en && r_timer_pend && mie_i[MIE_MTIE]) begin
                w_take     = 1'b1;
                w_is_int   = 1'b1;
                w_int_code = INT_CODE_TIMER;
                w_code     = int_cause(INT_CODE_TIMER);
            end
        end
    end

    // Vectored mode applies only to interrupts; mtvec modes 2/3 fall back to direct.
    always_comb begin
        w_new_pc = w_base;
        if (!w_is_int && (w_code == EXC_MRET)) begin
            w_new_pc = mepc_i;
        end else if (w_is_int && (mtvec_i[1:0] == 2'b01)) begin
            w_new_pc = w_base + {26'b0, w_int_code, 2'b00};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_take) w_state_next = ST_TRAP;
            ST_TRAP:   w_state_next = ST_SETTLE;
            ST_SETTLE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_excepttype <= ZERO_WORD;
            r_inst_addr  <= ZERO_WORD;
            r_flush      <= 1'b0;
            r_new_pc     <= ZERO_WORD;
        end else begin
            r_excepttype <= w_take ? w_code : ZERO_WORD;
            r_flush      <= w_take;
            if (w_take) begin
                r_inst_addr <= mem_inst_addr_i;
                r_new_pc    <= w_new_pc;
            end
        end
    end

    assign excepttype_o        = r_excepttype;
    assign current_inst_addr_o = r_inst_addr;
    assign flush_o             = r_flush;
    assign new_pc_o            = r_new_pc;

    assign w_unused = &{1'b0, mstatus_i[31:4], mstatus_i[2:0], mie_i[31:12], mie_i[10:8],
                        mie_i[6:4], mie_i[2:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed bench with trap scoreboard for trap_ctrl
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_int_i = 1'b0;
    logic        timer_int_i = 1'b0;
    logic        soft_int_i = 1'b0;
    logic [31:0] mem_excepttype_i = 32'h0;
    logic [31:0] mem_inst_addr_i = 32'h0;
    logic        mem_inst_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] mstatus_i = 32'h0;
    logic [31:0] mie_i = 32'h0;
    logic [31:0] mtvec_i = 32'h0;
    logic [31:0] mepc_i = 32'h0;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [2:0]  int_pending_o;

    typedef struct {
        logic [31:0] code;
        logic [31:0] addr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    trap_ctrl #(.SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ext_int_i           (ext_int_i),
        .timer_int_i         (timer_int_i),
        .soft_int_i          (soft_int_i),
        .mem_excepttype_i    (mem_excepttype_i),
        .mem_inst_addr_i     (mem_inst_addr_i),
        .mem_inst_valid_i    (mem_inst_valid_i),
        .stall_i             (stall_i),
        .mstatus_i           (mstatus_i),
        .mie_i               (mie_i),
        .mtvec_i             (mtvec_i),
        .mepc_i              (mepc_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .int_pending_o       (int_pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] code, input logic [31:0] addr, input logic [31:0] pc);
        exp_t e;
        e.code = code;
        e.addr = addr;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    // Every flush seen at the falling edge must match the oldest expected trap.
    always @(negedge clk) begin
        if (!rst && flush_o === 1'b1) begin
            exp_t e;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL spurious_flush observed=%h expected=none", excepttype_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_code", excepttype_o, e.code);
                chk("sb_addr", current_inst_addr_o, e.addr);
                chk("sb_pc", new_pc_o, e.pc);
            end
        end
    end

    initial begin
        #2;
        chk("rst_code", excepttype_o, 32'h0);
        chk("rst_addr", current_inst_addr_o, 32'h0);
        chk("rst_flush", {31'b0, flush_o}, 32'h0);
        chk("rst_pc", new_pc_o, 32'h0);
        chk("rst_pend", {29'b0, int_pending_o}, 32'h0);
        step(2);
        rst = 1'b0;

        // External interrupt, direct mode
        mstatus_i = 32'h8;
        mie_i     = 32'h888;
        mtvec_i   = 32'h100;
        ext_int_i = 1'b1;
        step(1);
        chk("ext_sync_lag", {29'b0, int_pending_o}, 32'h0);
        step(1);
        chk("ext_pend", {29'b0, int_pending_o}, 32'h4);
        mem_inst_valid_i = 1'b1;
        mem_inst_addr_i  = 32'h40;
        push(32'h8000_000B, 32'h40, 32'h100);
        step(1);
        mem_inst_valid_i = 1'b0;
        chk("ext_flush", {31'b0, flush_o}, 32'h1);
        chk("ext_code", excepttype_o, 32'h8000_000B);
        step(1);
        chk("ext_settle_flush", {31'b0, flush_o}, 32'h0);
        chk("ext_settle_code", excepttype_o, 32'h0);
        step(1);
        chk("ext_idle_flush", {31'b0, flush_o}, 32'h0);
        chk("ext_idle_pc", new_pc_o, 32'h100);
        ext_int_i = 1'b0;

        // Timer interrupt, vectored mode
        timer_int_i = 1'b1;
        mtvec_i     = 32'h101;
        step(3);
        chk("tmr_pend", {29'b0, int_pending_o}, 32'h2);
        mem_inst_valid_i = 1'b1;
        mem_inst_addr_i  = 32'h80;
        push(32'h8000_0007, 32'h80, 32'h11C);
        step(1);
        mem_inst_valid_i = 1'b0;
        timer_int_i = 1'b0;
        chk("tmr_pc", new_pc_o, 32'h11C);
        step(3);

        // mret, stall during TRAP must not hold the sequence
        mem_excepttype_i = 32'hA;
        mepc_i           = 32'h2000;
        mem_inst_valid_i = 1'b1;
        mem_inst_addr_i  = 32'h90;
        push(32'hA, 32'h90, 32'h2000);
        step(1);
        mem_excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        stall_i = 1'b1;
        chk("mret_flush", {31'b0, flush_o}, 32'h1);
        chk("mret_pc", new_pc_o, 32'h2000);
        step(1);
        chk("mret_one_cycle", {31'b0, flush_o}, 32'h0);
        step(1);
        stall_i = 1'b0;
        step(1);

        // ecall together with soft interrupt: exception first, soft after SETTLE
        soft_int_i = 1'b1;
        step(1);
        mem_excepttype_i = 32'h8;
        mem_inst_valid_i = 1'b1;
        mem_inst_addr_i  = 32'hA0;
        push(32'h8, 32'hA0, 32'h100);
        push(32'h8000_0000, 32'hA4, 32'h100);
        step(1);
        mem_excepttype_i = 32'h0;
        mem_inst_addr_i  = 32'hA4;
        chk("ecall_code", excepttype_o, 32'h8);
        step(1);
        chk("ecall_settle", {31'b0, flush_o}, 32'h0);
        step(1);
        chk("ecall_idle", {31'b0, flush_o}, 32'h0);
        step(1);
        mem_inst_valid_i = 1'b0;
        soft_int_i = 1'b0;
        chk("soft_code", excepttype_o, 32'h8000_0000);
        step(3);

        // Pending but blocked: MIE=0, stall, invalid, unknown exception code
        mstatus_i   = 32'h0;
        timer_int_i = 1'b1;
        mem_inst_valid_i = 1'b1;
        mem_excepttype_i = 32'h5;
        step(2);
        chk("mie0_flush", {31'b0, flush_o}, 32'h0);
        chk("mie0_pend", {29'b0, int_pending_o}, 32'h2);
        mem_excepttype_i = 32'h0;
        mstatus_i = 32'h8;
        stall_i   = 1'b1;
        step(2);
        chk("stall_flush", {31'b0, flush_o}, 32'h0);
        stall_i = 1'b0;
        mem_inst_valid_i = 1'b0;
        step(2);
        chk("invalid_flush", {31'b0, flush_o}, 32'h0);

        // Reset in the middle of TRAP
        mem_inst_valid_i = 1'b1;
        mem_inst_addr_i  = 32'hC0;
        step(1);
        mem_inst_valid_i = 1'b0;
        timer_int_i = 1'b0;
        chk("pre_rst_flush", {31'b0, flush_o}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_flush", {31'b0, flush_o}, 32'h0);
        chk("midrst_code", excepttype_o, 32'h0);
        chk("midrst_addr", current_inst_addr_o, 32'h0);
        chk("midrst_pc", new_pc_o, 32'h0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("post_rst_flush", {31'b0, flush_o}, 32'h0);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
